// File: rtl/executor_commit_lines.sv
// Commit executor: latches a falling piece, writes it into matrix memory, rescans the rows it covers
// and reports full lines before pulsing empty_o. Row scan/report is built only with EXECUTOR_COMMIT_SCAN_EN.
package executor_commit_lines_pkg;
  localparam int pf_width_lp  = 16;
  localparam int pf_height_lp = 32;

  typedef struct packed {
    logic [$clog2(pf_width_lp)-1:0]  x;
    logic [$clog2(pf_height_lp)-1:0] y;
  } point_t;
endpackage

module executor_commit_lines
  import executor_commit_lines_pkg::*;
#(
  parameter int width_p     = pf_width_lp,
  parameter int height_p    = pf_height_lp,
  parameter int shape_dim_p = 4
) (
  input  logic                                   clk_i,
  input  logic                                   reset_n_i,
  input  logic                                   v_i,
  output logic                                   ready_o,
  input  point_t                                 pos_i,
  input  logic [shape_dim_p-1:0][shape_dim_p-1:0] shape_i,
  output logic                                   empty_o,
  output point_t                                 mm_write_addr_o,
  output logic [shape_dim_p-1:0][shape_dim_p-1:0] mm_write_data_o,
  output logic                                   mm_write_v_o,
  input  logic                                   mm_is_ready_i,
  output logic [$clog2(height_p)-1:0]            mm_row_addr_o,
  output logic                                   mm_row_v_o,
  input  logic [width_p-1:0]                     mm_row_data_i,
  output logic                                   lines_v_o,
  input  logic                                   lines_ready_i,
  output logic [shape_dim_p-1:0]                 lines_mask_o,
  output logic [$clog2(shape_dim_p+1)-1:0]       lines_count_o
);
  localparam int yw = $clog2(height_p);
  localparam int sw = $clog2(shape_dim_p+1);

  typedef enum logic [2:0] {IDLE, WRITE, WAIT, SCAN, REPORT, EMPTY} state_t;

  state_t                                state_reg, state_next;
  point_t                                pos_reg;
  logic [shape_dim_p-1:0][shape_dim_p-1:0] shape_reg;
  logic                                  scan_last;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_reg <= IDLE;
      pos_reg   <= '0;
      shape_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (state_reg == IDLE && v_i) begin
        pos_reg   <= pos_i;
        shape_reg <= shape_i;
      end
    end
  end

  always_comb begin
    state_next   = state_reg;
    ready_o      = 1'b0;
    empty_o      = 1'b0;
    mm_write_v_o = 1'b0;
    case (state_reg)
      IDLE: begin
        ready_o = 1'b1;
        if (v_i) state_next = WRITE;
      end
      WRITE: begin
        mm_write_v_o = 1'b1;
        state_next   = WAIT;
      end
      WAIT: begin
`ifdef EXECUTOR_COMMIT_SCAN_EN
        if (mm_is_ready_i) state_next = SCAN;
`else
        if (mm_is_ready_i) state_next = EMPTY;
`endif
      end
`ifdef EXECUTOR_COMMIT_SCAN_EN
      SCAN:   if (scan_last) state_next = REPORT;
      REPORT: if (lines_ready_i) state_next = EMPTY;
`endif
      EMPTY: begin
        empty_o    = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign mm_write_addr_o = pos_reg;
  assign mm_write_data_o = shape_reg;

`ifdef EXECUTOR_COMMIT_SCAN_EN
  localparam logic [yw:0] height_lim = (yw+1)'(height_p);

  logic [sw-1:0]          step_reg;
  logic                   rd_made_reg;
  logic [shape_dim_p-1:0] mask_reg, mask_next;
  logic [shape_dim_p:0]   row_nz;
  logic [yw:0]            row_sum;
  logic                   rd_en, row_full;

  // One bit wider than the row address so pos.y+s past the bottom cannot wrap back into range
  assign row_sum   = {1'b0, pos_reg.y} + (yw+1)'(step_reg);
  assign row_full  = &mm_row_data_i;
  assign scan_last = (step_reg == sw'(shape_dim_p));
  assign row_nz[shape_dim_p] = 1'b0;
  assign rd_en = (state_reg == SCAN) && row_nz[step_reg] && (row_sum < height_lim);

  genvar gi;
  for (gi = 0; gi < shape_dim_p; gi++) begin : g_row
    assign row_nz[gi] = |shape_reg[gi];
    // Data for the read issued at step gi returns at step gi+1; mask clears on the way back to IDLE
    assign mask_next[gi] = (state_reg == SCAN && step_reg == sw'(gi + 1)) ? (rd_made_reg & row_full)
                                                                          : ((state_reg != EMPTY) & mask_reg[gi]);
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      step_reg    <= '0;
      rd_made_reg <= 1'b0;
      mask_reg    <= '0;
    end else begin
      step_reg    <= (state_reg == SCAN) ? step_reg + sw'(1) : '0;
      rd_made_reg <= rd_en;
      mask_reg    <= mask_next;
    end
  end

  always_comb begin
    lines_count_o = '0;
    for (int i = 0; i < shape_dim_p; i++) lines_count_o = lines_count_o + sw'(mask_reg[i]);
  end

  assign mm_row_v_o    = rd_en;
  assign mm_row_addr_o = rd_en ? row_sum[yw-1:0] : '0;
  assign lines_v_o     = (state_reg == REPORT);
  assign lines_mask_o  = mask_reg;
`else
  logic unused_in;

  assign scan_last     = 1'b0;
  assign unused_in     = ^{lines_ready_i, mm_row_data_i, scan_last};
  assign mm_row_v_o    = 1'b0;
  assign mm_row_addr_o = '0;
  assign lines_v_o     = 1'b0;
  assign lines_mask_o  = '0;
  assign lines_count_o = '0;
`endif
endmodule

// File: tb/tb_executor_commit_lines.sv
// Directed bench for executor_commit_lines; expectations follow EXECUTOR_COMMIT_SCAN_EN when it is defined.
module tb_executor_commit_lines;
  import executor_commit_lines_pkg::*;

`ifdef EXECUTOR_COMMIT_SCAN_EN
  localparam bit SCAN_EN = 1'b1;
`else
  localparam bit SCAN_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset_n;
  logic             v;
  logic             ready;
  point_t           pos;
  logic [3:0][3:0]  shape;
  logic             empty;
  point_t           wr_addr;
  logic [3:0][3:0]  wr_data;
  logic             wr_v;
  logic             mm_ready;
  logic [4:0]       row_addr;
  logic             row_v;
  logic [15:0]      row_data;
  logic             lines_v;
  logic             lines_ready;
  logic [3:0]       lines_mask;
  logic [2:0]       lines_count;

  executor_commit_lines dut (
    .clk_i(clk), .reset_n_i(reset_n), .v_i(v), .ready_o(ready), .pos_i(pos), .shape_i(shape),
    .empty_o(empty), .mm_write_addr_o(wr_addr), .mm_write_data_o(wr_data), .mm_write_v_o(wr_v),
    .mm_is_ready_i(mm_ready), .mm_row_addr_o(row_addr), .mm_row_v_o(row_v), .mm_row_data_i(row_data),
    .lines_v_o(lines_v), .lines_ready_i(lines_ready), .lines_mask_o(lines_mask), .lines_count_o(lines_count)
  );

  always #5 clk = ~clk;

  // Matrix memory stand-in: rows answer the cycle after a read; all-ones when no read was made
  logic [15:0] rows [32];
  logic        rd_q = 1'b0;
  logic [4:0]  addr_q = '0;
  assign row_data = rd_q ? rows[addr_q] : 16'hFFFF;

  int          total = 0, bad = 0;
  int          wr_cnt, empty_cnt, rd_num, rep_cycles;
  logic [31:0] rd_map;
  point_t      wr_addr_cap;
  logic [15:0] wr_data_cap;
  logic [3:0]  cap_mask;
  logic [2:0]  cap_count;
  bit          mask_unstable;

  always @(posedge clk) begin
    rd_q   <= row_v;
    addr_q <= row_addr;
    if (row_v) begin rd_num++; rd_map[row_addr] = 1'b1; end
    if (wr_v) begin wr_cnt++; wr_addr_cap = wr_addr; wr_data_cap = wr_data; end
    if (empty) empty_cnt++;
  end

  function automatic point_t mk_pt(input int x, input int y);
    point_t p;
    p.x = 4'(x);
    p.y = 5'(y);
    return p;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_rows();
    for (int i = 0; i < 32; i++) rows[i] = 16'h0000;
  endtask

  // Accepts one commit, then steps until empty_o: WAIT lasts w cycles, REPORT lasts r cycles
  task automatic run_commit(input point_t p, input logic [15:0] s, input int w, input int r,
                            input bit busy, output int lat);
    int  rep_seen;
    bit  done;
    wr_cnt = 0; empty_cnt = 0; rd_num = 0; rd_map = '0;
    cap_mask = '0; cap_count = '0; mask_unstable = 1'b0;
    lat = -1; rep_seen = 0; done = 1'b0;
    v = 1'b1; pos = p; shape = s; mm_ready = 1'b0; lines_ready = 1'b0;
    tick();
    v = 1'b0;
    for (int k = 1; k <= 60 && !done; k++) begin
      if (lines_v) begin
        rep_seen++;
        if (rep_seen == 1) begin cap_mask = lines_mask; cap_count = lines_count; end
        else if (lines_mask !== cap_mask) mask_unstable = 1'b1;
      end
      if (empty) begin lat = k; done = 1'b1; end
      mm_ready    = (k >= 1 + w);
      lines_ready = (rep_seen >= r);
      v           = busy && !done && (k % 2 == 0);
      pos         = v ? mk_pt(7, 7) : p;
      tick();
    end
    v = 1'b0; mm_ready = 1'b0; lines_ready = 1'b0; pos = p;
    rep_cycles = rep_seen;
    $display("commit x=%0d y=%0d shape=%h lat=%0d mask=%b count=%0d reads=%0d map=%h",
             p.x, p.y, s, lat, cap_mask, cap_count, rd_num, rd_map);
  endtask

  task automatic test_reset();
    total++; if (ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", ready); end
    total++; if ({empty, wr_v, row_v, lines_v} !== 4'b0)
      begin bad++; $display("FAIL reset_strobes got=%b want=0000", {empty, wr_v, row_v, lines_v}); end
    total++; if ({wr_addr, wr_data, row_addr, lines_mask, lines_count} !== '0)
      begin bad++; $display("FAIL reset_buses got=%h want=0", {wr_addr, wr_data, row_addr, lines_mask, lines_count}); end
  endtask

  task automatic test_basic();
    int lat;
    clear_rows();
    rows[10] = 16'h0FFF;
    run_commit(mk_pt(3, 10), 16'h000F, 1, 1, 1'b0, lat);
    total++; if (lat !== (SCAN_EN ? 9 : 3)) begin bad++; $display("FAIL basic_latency got=%0d want=%0d", lat, SCAN_EN ? 9 : 3); end
    total++; if (wr_cnt !== 1) begin bad++; $display("FAIL basic_write_pulses got=%0d want=1", wr_cnt); end
    total++; if (wr_addr_cap !== mk_pt(3, 10)) begin bad++; $display("FAIL basic_write_addr got=%h want=%h", wr_addr_cap, mk_pt(3, 10)); end
    total++; if (wr_data_cap !== 16'h000F) begin bad++; $display("FAIL basic_write_data got=%h want=000f", wr_data_cap); end
    total++; if (rd_map !== (SCAN_EN ? 32'h0000_0400 : 32'h0)) begin bad++; $display("FAIL basic_read_map got=%h", rd_map); end
    total++; if (rd_num !== (SCAN_EN ? 1 : 0)) begin bad++; $display("FAIL basic_read_count got=%0d", rd_num); end
    total++; if ({cap_mask, cap_count} !== 7'd0) begin bad++; $display("FAIL basic_mask got=%b/%0d want=0000/0", cap_mask, cap_count); end
    total++; if (rep_cycles !== (SCAN_EN ? 1 : 0)) begin bad++; $display("FAIL basic_report_cycles got=%0d", rep_cycles); end
    total++; if (empty_cnt !== 1) begin bad++; $display("FAIL basic_empty_pulses got=%0d want=1", empty_cnt); end
    total++; if (ready !== 1'b1) begin bad++; $display("FAIL basic_ready_after got=%b want=1", ready); end
  endtask

  task automatic test_full_lines();
    int lat;
    clear_rows();
    for (int i = 20; i < 24; i++) rows[i] = 16'hFFFF;
    run_commit(mk_pt(5, 20), 16'h0660, 1, 1, 1'b0, lat);
    total++; if (rd_map !== (SCAN_EN ? 32'h0060_0000 : 32'h0)) begin bad++; $display("FAIL full_read_map got=%h", rd_map); end
    total++; if (cap_mask !== (SCAN_EN ? 4'b0110 : 4'b0000)) begin bad++; $display("FAIL full_mask got=%b", cap_mask); end
    total++; if (cap_count !== (SCAN_EN ? 3'd2 : 3'd0)) begin bad++; $display("FAIL full_count got=%0d", cap_count); end
  endtask

  task automatic test_bottom();
    int lat;
    clear_rows();
    rows[30] = 16'hFFFF;
    rows[31] = 16'hFFFF;
    run_commit(mk_pt(0, 30), 16'hFFFF, 1, 1, 1'b0, lat);
    total++; if (rd_map !== (SCAN_EN ? 32'hC000_0000 : 32'h0)) begin bad++; $display("FAIL bottom_read_map got=%h", rd_map); end
    total++; if (cap_mask !== (SCAN_EN ? 4'b0011 : 4'b0000)) begin bad++; $display("FAIL bottom_mask got=%b", cap_mask); end
    total++; if (cap_count !== (SCAN_EN ? 3'd2 : 3'd0)) begin bad++; $display("FAIL bottom_count got=%0d", cap_count); end
    total++; if (lat !== (SCAN_EN ? 9 : 3)) begin bad++; $display("FAIL bottom_latency got=%0d", lat); end
  endtask

  task automatic test_backpressure();
    int lat;
    clear_rows();
    rows[5] = 16'hFFFF;
    rows[8] = 16'hFFFF;
    run_commit(mk_pt(0, 5), 16'h8001, 5, 4, 1'b1, lat);
    total++; if (lat !== (SCAN_EN ? 16 : 7)) begin bad++; $display("FAIL bp_latency got=%0d want=%0d", lat, SCAN_EN ? 16 : 7); end
    total++; if (rep_cycles !== (SCAN_EN ? 4 : 0)) begin bad++; $display("FAIL bp_report_cycles got=%0d", rep_cycles); end
    total++; if (mask_unstable !== 1'b0) begin bad++; $display("FAIL bp_mask_stable got=%b want=0", mask_unstable); end
    total++; if (cap_mask !== (SCAN_EN ? 4'b1001 : 4'b0000)) begin bad++; $display("FAIL bp_mask got=%b", cap_mask); end
    total++; if (rd_map !== (SCAN_EN ? 32'h0000_0120 : 32'h0)) begin bad++; $display("FAIL bp_read_map got=%h", rd_map); end
    total++; if (empty_cnt !== 1) begin bad++; $display("FAIL bp_empty_pulses got=%0d want=1", empty_cnt); end
    total++; if (wr_cnt !== 1) begin bad++; $display("FAIL bp_write_pulses got=%0d want=1", wr_cnt); end
    total++; if (wr_addr !== mk_pt(0, 5)) begin bad++; $display("FAIL bp_addr_held got=%h want=%h", wr_addr, mk_pt(0, 5)); end
  endtask

  task automatic test_reset_mid_scan();
    int lat;
    int stop_k;
    clear_rows();
    for (int i = 12; i < 16; i++) rows[i] = 16'hFFFF;
    stop_k = SCAN_EN ? 5 : 2;
    v = 1'b1; pos = mk_pt(2, 12); shape = 16'hFFFF; mm_ready = 1'b0;
    tick();
    v = 1'b0;
    for (int k = 1; k < stop_k; k++) begin
      mm_ready = (k >= 2);
      tick();
    end
    total++; if (row_v !== SCAN_EN) begin bad++; $display("FAIL midscan_read_strobe got=%b want=%b", row_v, SCAN_EN); end
    total++; if (row_addr !== (SCAN_EN ? 5'd14 : 5'd0)) begin bad++; $display("FAIL midscan_read_addr got=%0d", row_addr); end
    #2 reset_n = 1'b0;
    #1;
    $display("reset asserted mid-flight at step %0d", stop_k);
    total++; if (ready !== 1'b1) begin bad++; $display("FAIL midreset_ready got=%b want=1", ready); end
    total++; if ({empty, wr_v, row_v, lines_v, wr_addr, wr_data, row_addr, lines_mask, lines_count} !== '0)
      begin bad++; $display("FAIL midreset_outputs got=%h want=0", {empty, wr_v, row_v, lines_v, wr_addr, wr_data, row_addr, lines_mask, lines_count}); end
    mm_ready = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
    run_commit(mk_pt(1, 12), 16'hFFFF, 1, 1, 1'b0, lat);
    total++; if (lat !== (SCAN_EN ? 9 : 3)) begin bad++; $display("FAIL postreset_latency got=%0d", lat); end
    total++; if (cap_mask !== (SCAN_EN ? 4'b1111 : 4'b0000)) begin bad++; $display("FAIL postreset_mask got=%b", cap_mask); end
    total++; if (cap_count !== (SCAN_EN ? 3'd4 : 3'd0)) begin bad++; $display("FAIL postreset_count got=%0d", cap_count); end
  endtask

  task automatic test_back_to_back();
    int lat;
    clear_rows();
    rows[1] = 16'hFFFF;
    run_commit(mk_pt(8, 0), 16'h0010, 1, 1, 1'b0, lat);
    total++; if (cap_mask !== (SCAN_EN ? 4'b0010 : 4'b0000)) begin bad++; $display("FAIL b2b_first_mask got=%b", cap_mask); end
    total++; if (ready !== 1'b1) begin bad++; $display("FAIL b2b_ready got=%b want=1", ready); end
    run_commit(mk_pt(9, 3), 16'h1000, 1, 1, 1'b0, lat);
    total++; if (lat !== (SCAN_EN ? 9 : 3)) begin bad++; $display("FAIL b2b_latency got=%0d", lat); end
    total++; if (wr_addr_cap !== mk_pt(9, 3)) begin bad++; $display("FAIL b2b_write_addr got=%h want=%h", wr_addr_cap, mk_pt(9, 3)); end
    total++; if (rd_map !== (SCAN_EN ? 32'h0000_0040 : 32'h0)) begin bad++; $display("FAIL b2b_read_map got=%h", rd_map); end
    total++; if ({cap_mask, cap_count} !== 7'd0) begin bad++; $display("FAIL b2b_second_mask got=%b/%0d", cap_mask, cap_count); end
  endtask

  initial begin
    reset_n = 1'b0; v = 1'b0; pos = '0; shape = '0; mm_ready = 1'b0; lines_ready = 1'b0;
    clear_rows();
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    reset_n = 1'b1;
    tick();
    test_basic();
    test_full_lines();
    test_bottom();
    test_backpressure();
    test_reset_mid_scan();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
